// File: rtl/right_shifter_seq.sv
// right_shifter_seq: iterative 32-bit srl/sra, one shift-amount bit per cycle (clk,rst,start,arith,dataA,dataB -> out,busy,done)
module right_shifter_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        arith,
  input  logic [31:0] dataA,
  input  logic [4:0]  dataB,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t      state, state_n;
  logic [31:0] work, nxt;
  logic [4:0]  amt;
  logic        mode;
  logic [2:0]  stage;
  logic [63:0] ext;
  logic        last;
  always_comb begin
    ext     = {{32{mode & work[31]}}, work} >> (6'd1 << stage);
    nxt     = amt[stage] ? ext[31:0] : work;
    last    = stage == 3'd4;
    state_n = state == IDLE ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      amt   <= '0;
      mode  <= 1'b0;
      stage <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state_n == SHIFT;
      done  <= state == SHIFT && last;
      if (state == IDLE && start) begin
        work  <= dataA;
        amt   <= dataB;
        mode  <= arith;
        stage <= '0;
      end else if (state == SHIFT) begin
        work  <= nxt;
        stage <= last ? 3'd0 : stage + 3'd1;
        if (last) out <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_right_shifter_seq.sv
// tb_right_shifter_seq: directed and back-to-back random checks of right_shifter_seq
module tb_right_shifter_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        arith = 1'b0;
  logic [31:0] dataA = '0;
  logic [4:0]  dataB = '0;
  logic [31:0] out;
  logic        busy, done;
  int          n_cmp = 0;
  int          n_bad = 0;
  right_shifter_seq dut (
    .clk(clk), .rst(rst), .start(start), .arith(arith),
    .dataA(dataA), .dataB(dataB), .out(out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [4:0] b, input logic ar);
    @(negedge clk);
    dataA = a;
    dataB = b;
    arith = ar;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] b, input logic ar, input logic [31:0] exp);
    issue(a, b, ar);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done0"}, {31'd0, done}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_mid"}, {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_out"}, out, exp);
  endtask
  initial begin
    int dn;
    logic [31:0] got, exp, a;
    logic [4:0]  b;
    logic        ar;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    run_op("lsr31", 32'h80000000, 5'd31, 1'b0, 32'h00000001);
    run_op("asr31", 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF);
    run_op("asr4n", 32'hF0000000, 5'd4, 1'b1, 32'hFF000000);
    run_op("asr4p", 32'h70000000, 5'd4, 1'b1, 32'h07000000);
    run_op("lsr4n", 32'hF0000000, 5'd4, 1'b0, 32'h0F000000);
    run_op("asr31p", 32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000);
    run_op("asr21", 32'hA5A5A5A5, 5'd21, 1'b1, 32'hFFFFFD2D);
    run_op("zero", 32'h12345678, 5'd0, 1'b0, 32'h12345678);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_hold", out, 32'h12345678);
    chk("zero_nodone", {31'd0, done}, 32'd0);
    issue(32'hFFFF0000, 5'd8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    dataA = 32'h1;
    dataB = 5'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dn = 0;
    got = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dn++;
        got = out;
      end
    end
    chk("busy_ign_cnt", dn, 32'd1);
    chk("busy_ign_out", got, 32'h00FFFF00);
    issue(32'hDEADBEEF, 5'd3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_out", out, 32'h0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("abort_nodone", dn, 32'd0);
    run_op("post_rst", 32'h00000100, 5'd8, 1'b0, 32'h00000001);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    dataA = 32'hFFFFFFFF;
    dataB = 5'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_start_nodone", {31'd0, done}, 32'd0);
    a = $urandom;
    b = 5'($urandom_range(31));
    ar = 1'($urandom_range(1));
    issue(a, b, ar);
    for (int k = 0; k < 1000; k++) begin
      exp = ar ? 32'($signed(a) >>> b) : a >> b;
      dn = 0;
      do begin
        @(posedge clk);
        #1;
        dn++;
      end while (!done && dn < 20);
      chk("rnd_lat", dn, 32'd5);
      chk("rnd_out", out, exp);
      if (k == 999) break;
      a = $urandom;
      b = 5'($urandom_range(31));
      ar = 1'($urandom_range(1));
      dataA = a;
      dataB = b;
      arith = ar;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dataA = ~a;
      dataB = ~b;
      arith = ~ar;
      chk("rnd_accept", {31'd0, busy}, 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
